// File: rtl/aes_ctr_core.sv
// rtl/aes_ctr_core.sv - AES-128 ECB/CTR streaming encrypt engine with output FIFO
// Iterative core: one round per cycle, on-the-fly key schedule, slot-reserving FIFO.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Inverse as a^254 via an addition chain a^3, a^7 .. a^127, then one squaring; 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  logic [7:0] inv_w;
  assign inv_w = ginv(a_i);
  assign s_o   = inv_w ^ {inv_w[6:0], inv_w[7]} ^ {inv_w[5:0], inv_w[7:6]}
               ^ {inv_w[4:0], inv_w[7:5]} ^ {inv_w[3:0], inv_w[7:4]} ^ 8'h63;
endmodule

module aes_key_expand_128 (
  input  logic         clk,
  input  logic         rstn,
  input  logic         kld_i,
  input  logic         step_i,
  input  logic [127:0] key_i,
  output logic [127:0] rk_o,
  output logic [127:0] rk_next_o
);
  logic [127:0] rk_q;
  logic [7:0]   rcon_q;
  logic [31:0]  rot_w, sub_w, t_w, n0_w, n1_w, n2_w, n3_w;

  assign rot_w = {rk_q[23:0], rk_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sbox (.a_i(rot_w[8*i +: 8]), .s_o(sub_w[8*i +: 8]));
  end

  assign t_w       = sub_w ^ {rcon_q, 24'h0};
  assign n0_w      = rk_q[127:96] ^ t_w;
  assign n1_w      = rk_q[95:64]  ^ n0_w;
  assign n2_w      = rk_q[63:32]  ^ n1_w;
  assign n3_w      = rk_q[31:0]   ^ n2_w;
  assign rk_next_o = {n0_w, n1_w, n2_w, n3_w};
  assign rk_o      = rk_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rk_q   <= '0;
      rcon_q <= 8'h01;
    end else if (kld_i) begin
      rk_q   <= key_i;
      rcon_q <= 8'h01;
    end else if (step_i) begin
      rk_q   <= rk_next_o;
      rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end
endmodule

module aes_ctr_core #(
  parameter int CTR_W      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [127:0]       cfg_key,
  input  logic [127-CTR_W:0] cfg_nonce,
  input  logic [CTR_W-1:0]   cfg_ctr_init,
  input  logic               cfg_ctr_ld,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [CTR_W-1:0]   ctr_value,
  output logic               ctr_wrap,
  output logic               busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_PUSH} state_e;

  state_e           st_q, st_d;
  logic             ld_ph_q;
  logic [3:0]       rnd_q;
  logic [127:0]     key_q, data_q, block_q, state_q;
  logic             mode_q;
  logic [CTR_W-1:0] ctr_q;
  logic             wrap_q, in_ready_q, busy_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [127:0]     mem [FIFO_DEPTH];

  logic         rstn, accept, push, pop, kld, kstep;
  logic [127:0] rk_w, rk_next_w, sb_w, sr_w, mc_w, round_w, push_data_w;

  assign rstn   = ~rst;
  assign accept = (st_q == S_IDLE) && in_valid && in_ready_q;
  assign push   = (st_q == S_PUSH);
  assign pop    = out_valid && out_ready;
  assign kld    = (st_q == S_LOAD) && !ld_ph_q;
  assign kstep  = (st_q == S_ROUND);
  assign cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);

  aes_key_expand_128 u_kexp (
    .clk      (clk),
    .rstn     (rstn),
    .kld_i    (kld),
    .step_i   (kstep),
    .key_i    (key_q),
    .rk_o     (rk_w),
    .rk_next_o(rk_next_w)
  );

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a_i(state_q[127-8*i -: 8]), .s_o(sb_w[127-8*i -: 8]));
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of the block sits at [127-8k]; column c holds bytes 4c..4c+3, row r = k % 4.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    sr_w = '0;
    mc_w = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_w[127-8*(4*c+r) -: 8] = sb_w[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr_w[127-32*c -: 8];
      a1 = sr_w[119-32*c -: 8];
      a2 = sr_w[111-32*c -: 8];
      a3 = sr_w[103-32*c -: 8];
      mc_w[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc_w[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc_w[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc_w[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  assign round_w     = ((rnd_q == 4'd10) ? sr_w : mc_w) ^ rk_next_w;
  assign push_data_w = mode_q ? (state_q ^ data_q) : state_q;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:  if (accept) st_d = S_LOAD;
      S_LOAD:  if (ld_ph_q) st_d = S_ROUND;
      S_ROUND: if (rnd_q == 4'd10) st_d = S_PUSH;
      S_PUSH:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= S_IDLE;
      ld_ph_q    <= 1'b0;
      rnd_q      <= '0;
      key_q      <= '0;
      data_q     <= '0;
      block_q    <= '0;
      state_q    <= '0;
      mode_q     <= 1'b0;
      ctr_q      <= '0;
      wrap_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      st_q <= st_d;
      // Idle with a free slot means nothing is in flight, so cnt_d alone decides readiness.
      in_ready_q <= (st_d == S_IDLE) && (cnt_d < CNT_W'(FIFO_DEPTH));
      busy_q     <= (st_d != S_IDLE);
      unique case (st_q)
        S_IDLE: begin
          if (accept) begin
            key_q   <= cfg_key;
            mode_q  <= mode;
            data_q  <= in_data;
            block_q <= mode ? {cfg_nonce, ctr_q} : in_data;
            ld_ph_q <= 1'b0;
          end
        end
        S_LOAD: begin
          ld_ph_q <= 1'b1;
          if (ld_ph_q) begin
            state_q <= block_q ^ rk_w;
            rnd_q   <= 4'd1;
          end
        end
        S_ROUND: begin
          state_q <= round_w;
          rnd_q   <= rnd_q + 4'd1;
        end
        default: ;
      endcase
      if (accept && mode) begin
        ctr_q <= ctr_q + CTR_W'(1);
        if (&ctr_q) wrap_q <= 1'b1;
      end else if (cfg_ctr_ld && (st_q == S_IDLE) && !accept) begin
        ctr_q  <= cfg_ctr_init;
        wrap_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data_w;
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign ctr_value = ctr_q;
  assign ctr_wrap  = wrap_q;
endmodule

// File: tb/tb_aes_ctr_core.sv
// tb/tb_aes_ctr_core.sv - directed bench for aes_ctr_core with cycle-level reference model
module tb_aes_ctr_core;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] cfg_key = '0;
  logic [95:0]  cfg_nonce = '0;
  logic [31:0]  cfg_ctr_init = '0;
  logic         cfg_ctr_ld = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, ctr_wrap, busy;
  logic [127:0] out_data;
  logic [31:0]  ctr_value;

  aes_ctr_core #(.CTR_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
    .cfg_ctr_init(cfg_ctr_init), .cfg_ctr_ld(cfg_ctr_ld), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ctr_value(ctr_value), .ctr_wrap(ctr_wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_edge = 0;
  logic [7:0] sbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = sbox[s[row+4*((c+row)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Reference model: every accepted block emerges 13 edges later, in order; the engine is
  // unavailable for 13 edges after an accept and whenever the queue of owed blocks is full.
  logic [127:0] q_data [$];
  int           q_time [$];
  logic [31:0]  m_ctr = '0;
  logic         m_wrap = 1'b0, m_busy = 1'b0, m_in_ready = 1'b0;
  int           busy_until = 0;
  logic         mdl_pv, mdl_acc;
  logic [127:0] mdl_blk, mdl_c;
  int           mdl_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data.delete();
      q_time.delete();
      m_ctr = '0;
      m_wrap = 1'b0;
      m_busy = 1'b0;
      m_in_ready = 1'b0;
      busy_until = 0;
    end else begin
      mdl_e  = cyc + 1;
      mdl_pv = (q_data.size() > 0) && (q_time[0] <= cyc);
      if (mdl_pv && out_ready) begin
        void'(q_data.pop_front());
        void'(q_time.pop_front());
      end
      mdl_acc = in_valid && m_in_ready;
      if (mdl_acc) begin
        mdl_blk = mode ? {cfg_nonce, m_ctr} : in_data;
        mdl_c   = aes_enc(cfg_key, mdl_blk);
        q_data.push_back(mode ? (mdl_c ^ in_data) : mdl_c);
        q_time.push_back(mdl_e + 13);
        busy_until = mdl_e + 13;
        if (mode) begin
          if (m_ctr == 32'hffffffff) m_wrap = 1'b1;
          m_ctr = m_ctr + 32'd1;
        end
      end else if (cfg_ctr_ld && !m_busy) begin
        m_ctr  = cfg_ctr_init;
        m_wrap = 1'b0;
      end
      cyc = mdl_e;
      m_busy = (cyc < busy_until);
      m_in_ready = !m_busy && (q_data.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_ctr_value", ctr_value, 0);
      chk("rst_ctr_wrap", ctr_wrap, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("in_ready", in_ready, m_in_ready);
      chk("busy", busy, m_busy);
      chk("ctr_value", ctr_value, m_ctr);
      chk("ctr_wrap", ctr_wrap, m_wrap);
      if ((q_data.size() > 0) && (q_time[0] <= cyc)) begin
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, q_data[0]);
      end else begin
        chk("out_valid", out_valid, 0);
      end
    end
  end

  task automatic send(input logic m, input logic [127:0] k, input logic [95:0] n,
                      input logic [127:0] d, input logic ld);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_in_ready", in_ready, 1);
    acc_edge = cyc + 1;
    #1;
    mode = m; cfg_key = k; cfg_nonce = n; in_data = d; in_valid = 1'b1; cfg_ctr_ld = ld;
    @(posedge clk);
    #1;
    // Scramble configuration so a block in flight must rely on its captured copy.
    in_valid = 1'b0; cfg_ctr_ld = 1'b0;
    cfg_key = ~k; cfg_nonce = ~n; mode = ~m; in_data = ~d;
  endtask

  task automatic wait_out(output logic [127:0] d, output int lat);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("wait_out_valid", out_valid, 1);
    d = out_data;
    lat = cyc - acc_edge;
  endtask

  task automatic ld_pulse(input logic [31:0] v);
    @(negedge clk);
    #1; cfg_ctr_init = v; cfg_ctr_ld = 1'b1;
    @(negedge clk);
    #1; cfg_ctr_ld = 1'b0;
  endtask

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [95:0]  N2  = 96'hf0f1f2f3f4f5f6f7f8f9fafb;
  localparam logic [127:0] P2A = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2A = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] P2B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2B = 128'h9806f66b7970fdff8617187bb9fffdff;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] d, e0, e1;
    logic [127:0] g [4];
    int           lat, got;

    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;

    chk("model_sbox_53", sbox[8'h53], 8'hed);
    chk("model_fips", aes_enc(K1, P1), C1);
    chk("model_sp800", aes_enc(K2, {N2, 32'hfcfdfeff}) ^ P2A, C2A);

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    send(1'b0, K1, 96'h0, P1, 1'b0);
    wait_out(d, lat);
    chk("fips_out", d, C1);
    chk("fips_latency", lat, 13);
    chk("ecb_ctr_unchanged", ctr_value, 0);

    ld_pulse(32'hfcfdfeff);
    chk("ctr_load", ctr_value, 32'hfcfdfeff);
    send(1'b1, K2, N2, P2A, 1'b0);
    wait_out(d, lat);
    chk("sp800_blk1", d, C2A);
    send(1'b1, K2, N2, P2B, 1'b0);
    wait_out(d, lat);
    chk("sp800_blk2", d, C2B);
    chk("sp800_ctr", ctr_value, 32'hfcfdff01);

    ld_pulse(32'hffffffff);
    send(1'b1, K2, N2, 128'h0123456789abcdef0011223344556677, 1'b0);
    wait_out(d, lat);
    chk("wrap_blk1", d, aes_enc(K2, {N2, 32'hffffffff}) ^ 128'h0123456789abcdef0011223344556677);
    chk("wrap_ctr1", ctr_value, 0);
    chk("wrap_flag1", ctr_wrap, 1);
    send(1'b1, K2, N2, 128'hfedcba98765432100f1e2d3c4b5a6978, 1'b0);
    wait_out(d, lat);
    chk("wrap_blk2", d, aes_enc(K2, {N2, 32'h00000000}) ^ 128'hfedcba98765432100f1e2d3c4b5a6978);
    chk("wrap_ctr2", ctr_value, 1);
    chk("wrap_flag2", ctr_wrap, 1);
    ld_pulse(32'h5);
    chk("ld_clears_wrap", ctr_wrap, 0);
    chk("ld_ctr5", ctr_value, 5);

    cfg_ctr_init = 32'h1234;
    send(1'b1, K1, N2, P1, 1'b1);
    chk("ld_vs_accept", ctr_value, 6);
    repeat (3) @(negedge clk);
    chk("busy_mid", busy, 1);
    ld_pulse(32'haaaa);
    wait_out(d, lat);
    chk("ld_while_busy", ctr_value, 6);

    @(negedge clk);
    #1 out_ready = 1'b0;
    e0 = aes_enc(K1, 128'h11111111222222223333333344444444);
    e1 = aes_enc(K1, 128'h55555555666666667777777788888888);
    send(1'b0, K1, 96'h0, 128'h11111111222222223333333344444444, 1'b0);
    send(1'b0, K1, 96'h0, 128'h55555555666666667777777788888888, 1'b0);
    repeat (30) @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold", out_data, e0);
    #1 out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && got < 4) begin
        g[got] = out_data;
        got++;
      end
      @(negedge clk);
    end
    chk("bp_count", got, 2);
    chk("bp_first", g[0], e0);
    chk("bp_second", g[1], e1);

    send(1'b0, K1, 96'h0, P1, 1'b0);
    repeat (7) @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_ctr", ctr_value, 0);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_out", out_valid, 0);
    send(1'b0, K1, 96'h0, P1, 1'b0);
    wait_out(d, lat);
    chk("post_rst_fips", d, C1);
    chk("post_rst_latency", lat, 13);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
